// File: rtl/bp_stream_pump_in_wrap.sv
// Bus-to-FSM stream pump: buffers {header,data} beats and presents one FSM beat per cycle with a
// per-beat address, in wrapped (critical-first) or aligned incrementing burst order.
module bp_stream_pump_in_wrap #(
  parameter int unsigned paddr_width_p       = 40,
  parameter int unsigned msg_type_width_p    = 4,
  parameter int unsigned size_width_p        = 3,
  parameter int unsigned stream_data_width_p = 64,
  parameter int unsigned block_width_p       = 512,
  parameter logic [(2**msg_type_width_p)-1:0] payload_mask_p = '0,
  parameter int unsigned fifo_els_p          = 2,
  parameter int unsigned wrap_mode_p         = 1,
  localparam int unsigned hdr_width_lp    = msg_type_width_p + size_width_p + paddr_width_p,
  localparam int unsigned stream_words_lp = block_width_p / stream_data_width_p,
  localparam int unsigned lg_words_lp     = $clog2(stream_words_lp)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [hdr_width_lp-1:0]        mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  output logic                           mem_ready_o,
  output logic [hdr_width_lp-1:0]        fsm_base_header_o,
  output logic [paddr_width_p-1:0]       fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic [lg_words_lp-1:0]         fsm_cnt_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_yumi_i,
  output logic                           new_o,
  output logic                           done_o
);

  localparam int unsigned off_lp   = $clog2(stream_data_width_p / 8);
  localparam int unsigned ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam logic [msg_type_width_p-1:0] wr_lp    = msg_type_width_p'(1);
  localparam logic [msg_type_width_p-1:0] uc_wr_lp = msg_type_width_p'(3);

  typedef logic [lg_words_lp-1:0] idx_t;
  typedef enum logic {e_ready, e_stream} state_e;

  // Input buffer
  logic [hdr_width_lp-1:0]        hdr_mem  [fifo_els_p];
  logic [stream_data_width_p-1:0] data_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]            wptr_q, rptr_q;
  logic [ptr_w_lp:0]              count_q;
  logic                           full, empty, enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == (ptr_w_lp + 1)'(fifo_els_p));
  assign empty       = (count_q == '0);
  assign mem_ready_o = ~full & ~reset_i;
  assign enq         = mem_v_i & mem_ready_o;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      hdr_mem[wptr_q]  <= mem_header_i;
      data_mem[wptr_q] <= mem_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wptr_q <= ptr_inc(wptr_q);
      if (deq) rptr_q <= ptr_inc(rptr_q);
      if (enq && !deq)      count_q <= count_q + 1'b1;
      else if (!enq && deq) count_q <= count_q - 1'b1;
    end
  end

  // Burst decode
  state_e                        state_q;
  idx_t                          cnt_q;
  logic [hdr_width_lp-1:0]       hdr_q, cur_hdr;
  logic [msg_type_width_p-1:0]   cur_type;
  logic [size_width_p-1:0]       cur_size;
  logic [paddr_width_p-1:0]      cur_addr, stream_addr;
  logic [off_lp-1:0]             low_bits;
  int                            lg_beats;
  idx_t                          beat_mask, first, base, idx;
  logic                          is_write, is_payload, single, last, streaming, fire;

  // Once streaming, the header captured with the first beat governs the whole burst
  assign streaming = (state_q == e_stream);
  assign cur_hdr   = streaming ? hdr_q : hdr_mem[rptr_q];
  assign cur_type  = cur_hdr[hdr_width_lp-1 -: msg_type_width_p];
  assign cur_size  = cur_hdr[paddr_width_p +: size_width_p];
  assign cur_addr  = cur_hdr[paddr_width_p-1:0];

  always_comb begin
    lg_beats = 0;
    if (int'(cur_size) > int'(off_lp)) lg_beats = int'(cur_size) - int'(off_lp);
    if (lg_beats > int'(lg_words_lp)) lg_beats = int'(lg_words_lp);
  end

  assign beat_mask  = idx_t'((32'd1 << lg_beats) - 32'd1);
  assign is_write   = (cur_type == wr_lp) || (cur_type == uc_wr_lp);
  assign is_payload = payload_mask_p[cur_type];
  assign single     = (beat_mask == '0) || (is_write && !is_payload);
  assign first      = cur_addr[off_lp +: lg_words_lp];
  assign base       = first & ~beat_mask;
  assign last       = (cnt_q == beat_mask);

  always_comb begin
    if (wrap_mode_p != 0) begin
      idx      = base | ((first + cnt_q) & beat_mask);
      low_bits = cur_addr[off_lp-1:0];
    end else begin
      idx      = base | (cnt_q & beat_mask);
      low_bits = '0;
    end
  end

  assign stream_addr = {cur_addr[paddr_width_p-1:off_lp+lg_words_lp], idx, low_bits};

  assign fsm_v_o           = ~empty;
  assign fire              = fsm_v_o & fsm_yumi_i;
  assign fsm_base_header_o = cur_hdr;
  assign fsm_data_o        = data_mem[rptr_q];
  assign fsm_addr_o        = single ? cur_addr : stream_addr;
  assign fsm_cnt_o         = single ? first : idx;
  assign new_o             = fire & ~single & ~streaming;
  assign done_o            = fire & (single | (streaming & last));
  // Non-payload bursts reuse one buffer entry until the final beat
  assign deq               = fire & (is_payload | single | (streaming & last));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      hdr_q   <= '0;
    end else if (fire) begin
      unique case (state_q)
        e_ready: if (!single) begin
          state_q <= e_stream;
          cnt_q   <= idx_t'(1);
          hdr_q   <= cur_hdr;
        end
        e_stream: if (last) begin
          state_q <= e_ready;
          cnt_q   <= '0;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i) fsm_yumi_i |-> fsm_v_o);
  a_align:  assert property (@(posedge clk_i) disable iff (reset_i)
                             fsm_v_o |-> (cur_addr[off_lp-1:0] == '0));
`endif

endmodule

// File: tb/tb_bp_stream_pump_in_wrap.sv
// Randomized bench for bp_stream_pump_in_wrap: a wrapping and an incrementing instance share
// stimulus and are checked against a per-message beat list built from the burst rules.
module tb_bp_stream_pump_in_wrap;

  localparam int HW = 4 + 3 + 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [HW-1:0] mem_header = '0;
  logic [63:0]   mem_data = '0;
  logic          mem_v = 1'b0;
  logic          fsm_yumi = 1'b0;

  logic          ready1, v1, new1, done1, ready0, v0, new0, done0;
  logic [HW-1:0] hdr1, hdr0;
  logic [39:0]   addr1, addr0;
  logic [63:0]   data1, data0;
  logic [2:0]    cnt1, cnt0;

  always #5 clk = ~clk;

  bp_stream_pump_in_wrap #(.payload_mask_p(16'h0002), .fifo_els_p(4), .wrap_mode_p(1)) u_dut (
    .clk_i(clk), .reset_i(rst), .mem_header_i(mem_header), .mem_data_i(mem_data),
    .mem_v_i(mem_v), .mem_ready_o(ready1), .fsm_base_header_o(hdr1), .fsm_addr_o(addr1),
    .fsm_data_o(data1), .fsm_cnt_o(cnt1), .fsm_v_o(v1), .fsm_yumi_i(fsm_yumi),
    .new_o(new1), .done_o(done1)
  );

  bp_stream_pump_in_wrap #(.payload_mask_p(16'h0002), .fifo_els_p(4), .wrap_mode_p(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .mem_header_i(mem_header), .mem_data_i(mem_data),
    .mem_v_i(mem_v), .mem_ready_o(ready0), .fsm_base_header_o(hdr0), .fsm_addr_o(addr0),
    .fsm_data_o(data0), .fsm_cnt_o(cnt0), .fsm_v_o(v0), .fsm_yumi_i(fsm_yumi),
    .new_o(new0), .done_o(done0)
  );

  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [63:0]   data;
  } ent_t;

  typedef struct {
    logic [39:0]   a1, a0;
    logic [2:0]    c1, c0;
    logic [63:0]   data;
    logic [HW-1:0] hdr;
    bit            chk_data, nw, dn, dq;
  } beat_t;

  ent_t  in_q[$];
  beat_t exp_q[$];
  int    occ = 0;
  int    checks = 0;
  int    failures = 0;
  int    v_pct = 100;
  int    yumi_pct = 100;
  int    cyc = 0;
  bit    b2b_mode = 0;
  int    b2b_news = 0;
  int    last_done_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int beats_of(input int size);
    int b = (1 << size) / 8;
    if (b < 1) b = 1;
    if (b > 8) b = 8;
    return b;
  endfunction

  // Types: 0 rd, 1 wr (payload), 2 uc_rd, 3 uc_wr (no payload)
  task automatic push_msg(input int t, input int size, input logic [39:0] a);
    bit            payload = (t == 1);
    bit            is_wr = (t == 1) || (t == 3);
    int            beats = beats_of(size);
    bit            single = (beats == 1) || (is_wr && !payload);
    int            n = single ? 1 : beats;
    int            first = int'(a[5:3]);
    int            base = first & ~(beats - 1);
    logic [HW-1:0] hdr = {4'(t), 3'(size), a};
    for (int k = 0; k < n; k++) begin
      beat_t       b;
      logic [63:0] d = {$urandom, $urandom};
      int          i1 = base + ((first + k) % beats);
      int          i0 = base + k;
      if (payload || k == 0) in_q.push_back('{hdr: hdr, data: d});
      if (single) begin
        b.a1 = a; b.a0 = a; b.c1 = a[5:3]; b.c0 = a[5:3];
      end else begin
        b.a1 = {a[39:6], 3'(i1), a[2:0]};
        b.a0 = {a[39:6], 3'(i0), 3'b000};
        b.c1 = 3'(i1);
        b.c0 = 3'(i0);
      end
      b.hdr = hdr; b.data = d; b.chk_data = payload;
      b.nw = !single && (k == 0);
      b.dn = (k == n - 1);
      b.dq = payload || (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    beat_t b;
    bit    exp_ready;
    bit    fired;
    @(negedge clk);
    mem_v = (in_q.size() > 0) && ($urandom_range(99) < v_pct);
    if (in_q.size() > 0) begin
      mem_header = in_q[0].hdr;
      mem_data   = in_q[0].data;
    end
    fsm_yumi = v1 && ($urandom_range(99) < yumi_pct);
    #1;
    exp_ready = (occ < 4);
    check_eq("mem_ready", ready1, exp_ready);
    check_eq("mem_ready_m0", ready0, exp_ready);
    check_eq("fsm_v", v1, occ != 0);
    check_eq("fsm_v_m0", v0, occ != 0);
    fired = 0;
    if (v1 && exp_q.size() > 0) begin
      b = exp_q[0];
      fired = fsm_yumi;
      check_eq("addr_wrap", addr1, b.a1);
      check_eq("cnt_wrap", cnt1, b.c1);
      check_eq("addr_incr", addr0, b.a0);
      check_eq("cnt_incr", cnt0, b.c0);
      check_eq("base_hdr", hdr1, b.hdr);
      check_eq("new", new1, fired && b.nw);
      check_eq("done", done1, fired && b.dn);
      check_eq("new_m0", new0, fired && b.nw);
      check_eq("done_m0", done0, fired && b.dn);
      if (b.chk_data) check_eq("data", data1, b.data);
      if (fired && b.dn) last_done_cyc = cyc;
      if (fired && b.nw && b2b_mode) begin
        b2b_news++;
        if (b2b_news == 2) check_eq("b2b_gap", 64'(cyc - last_done_cyc), 64'd1);
      end
    end else begin
      check_eq("new_idle", new1, 1'b0);
      check_eq("done_idle", done1, 1'b0);
    end
    if (mem_v && exp_ready) begin
      void'(in_q.pop_front());
      occ++;
    end
    if (fired) begin
      if (b.dq) occ--;
      void'(exp_q.pop_front());
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    check_eq("drain_timeout", 64'(exp_q.size() + in_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_ready", ready1, 1'b0);
    check_eq("rst_v", v1, 1'b0);
    check_eq("rst_new", new1, 1'b0);
    check_eq("rst_done", done1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed bursts
    push_msg(2, 3, 40'h1008);
    drain();
    push_msg(0, 6, 40'h1028);
    drain();
    push_msg(1, 5, 40'h2010);
    drain();

    // Stall at beat 2
    push_msg(0, 6, 40'h4030);
    while (exp_q.size() > 6) step();
    yumi_pct = 0;
    repeat (3) step();
    yumi_pct = 100;
    drain();

    // Back-to-back reads
    b2b_mode = 1;
    push_msg(0, 6, 40'h5018);
    push_msg(2, 6, 40'h6020);
    drain();
    b2b_mode = 0;
    check_eq("b2b_seen", 64'(b2b_news), 64'd2);

    // Fill the buffer with the consumer stalled
    yumi_pct = 0;
    for (int i = 0; i < 5; i++) push_msg(2, 3, 40'h7000 + 40'(i * 8));
    repeat (8) step();
    check_eq("full_ready", ready1, 1'b0);
    yumi_pct = 100;
    drain();

    // Asynchronous reset mid-burst
    push_msg(0, 6, 40'h8038);
    while (exp_q.size() > 5) step();
    @(negedge clk);
    fsm_yumi = 1'b0;
    mem_v = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_v", v1, 1'b0);
    check_eq("arst_ready", ready1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    occ = 0;
    push_msg(0, 6, 40'h9010);
    drain();

    // Randomized traffic
    for (int m = 0; m < 300; m++) begin
      int t = int'($urandom_range(3));
      int s = int'($urandom_range(6));
      push_msg(t, s, {8'h00, $urandom} & 40'hFF_FFFF_FFF8);
      v_pct = int'($urandom_range(30, 100));
      yumi_pct = int'($urandom_range(30, 100));
      if ($urandom_range(3) == 0) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
